// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, funct and ALU select constants plus immediate sign extension
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] RESET_SEL = ALU_AND;
    function automatic logic [31:0] sext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction
endpackage

// File: rtl/id_ex_stage_regfile.sv
// regfile: 32x32 register file, two async read ports with write bypass, one sync write port.
// Ports: clk, rst (async, active-high); ra1/ra2 -> rd1/rd2 reads; we/wa/wd write port.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] mem [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = ra1 == 5'd0 ? 32'd0 : (we && wa == ra1) ? wd : mem[ra1];
        rd2 = ra2 == 5'd0 ? 32'd0 : (we && wa == ra2) ? wd : mem[ra2];
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, register read and ID/EX pipeline register feeding the ALU.
// Ports: clk, rst (async, active-high); instr/instr_valid in ID; stall/flush pipeline control;
// wb_en/wb_addr/wb_data write-back; operand1/operand2/sel/ex_valid/ex_dest/ex_reg_write/illegal to EX.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  sel,
    output logic        ex_valid,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        illegal
);
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic        legal, use_imm, reg_write;
    logic [2:0]  d_sel;
    logic [4:0]  dest;
    logic        take;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];

    regfile u_rf (
        .clk(clk), .rst(rst),
        .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
        .we(wb_en), .wa(wb_addr), .wd(wb_data)
    );

    always_comb begin
        legal     = 1'b1;
        use_imm   = 1'b1;
        reg_write = 1'b0;
        d_sel     = ALU_ADD;
        dest      = rt;
        case (opcode)
            OP_RTYPE: begin
                use_imm   = 1'b0;
                reg_write = 1'b1;
                dest      = rd;
                case (funct)
                    FN_ADD:  d_sel = ALU_ADD;
                    FN_SUB:  d_sel = ALU_SUB;
                    FN_AND:  d_sel = ALU_AND;
                    FN_OR:   d_sel = ALU_OR;
                    FN_NOR:  d_sel = ALU_NOR;
                    FN_SLT:  d_sel = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW: reg_write = 1'b1;
            OP_SW:   dest = 5'd0;
            OP_BEQ: begin
                use_imm = 1'b0;
                d_sel   = ALU_SUB;
                dest    = 5'd0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Only a valid, legal instruction becomes a real EX entry; everything else loads a bubble.
    assign take = instr_valid && legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand1     <= '0;
            operand2     <= '0;
            sel          <= RESET_SEL;
            ex_valid     <= 1'b0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
            illegal      <= 1'b0;
        end else if (flush) begin
            operand1     <= '0;
            operand2     <= '0;
            sel          <= RESET_SEL;
            ex_valid     <= 1'b0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
            illegal      <= 1'b0;
        end else if (stall) begin
            illegal      <= 1'b0;
        end else begin
            operand1     <= take ? rs_val : '0;
            operand2     <= !take ? '0 : use_imm ? sext(instr[15:0]) : rt_val;
            sel          <= take ? d_sel : RESET_SEL;
            ex_valid     <= take;
            ex_dest      <= take ? dest : '0;
            ex_reg_write <= take && reg_write;
            illegal      <= instr_valid && !legal;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] operand1, operand2;
    logic [2:0]  sel;
    logic        ex_valid, ex_reg_write, illegal;
    logic [4:0]  ex_dest;
    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .operand1(operand1), .operand2(operand2), .sel(sel), .ex_valid(ex_valid),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        instr_valid = v; instr = i; wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic chk_ex(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                          input logic [2:0] s, input logic v, input logic [4:0] d,
                          input logic rw, input logic il);
        chk({tag, ".op1"}, operand1, o1);
        chk({tag, ".op2"}, operand2, o2);
        chk({tag, ".sel"}, {29'd0, sel}, {29'd0, s});
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".dest"}, {27'd0, ex_dest}, {27'd0, d});
        chk({tag, ".rw"}, {31'd0, ex_reg_write}, {31'd0, rw});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, il});
    endtask

    initial begin
        tick(); tick();
        chk_ex("reset", 0, 0, 3'b000, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 1, 5'd1, 32'd5); tick();
        chk_ex("idle_bubble", 0, 0, 3'b000, 0, 0, 0, 0);
        drive(0, 0, 1, 5'd2, 32'd7); tick();
        drive(1, 32'h00221820, 0, 0, 0); tick();
        chk_ex("add", 32'd5, 32'd7, 3'b010, 1, 5'd3, 1, 0);
        drive(1, 32'h2024FFFF, 1, 5'd1, 32'h10); tick();
        chk_ex("bypass_addi", 32'h10, 32'hFFFFFFFF, 3'b010, 1, 5'd4, 1, 0);
        drive(1, 32'h00222822, 0, 0, 0); tick();
        chk_ex("sub", 32'h10, 32'd7, 3'b110, 1, 5'd5, 1, 0);
        stall = 1'b1;
        drive(1, 32'h00221820, 1, 5'd2, 32'h99); tick();
        chk_ex("stall1", 32'h10, 32'd7, 3'b110, 1, 5'd5, 1, 0);
        drive(1, 32'hFC000000, 0, 0, 0); tick();
        chk_ex("stall2_no_illegal", 32'h10, 32'd7, 3'b110, 1, 5'd5, 1, 0);
        flush = 1'b1;
        drive(1, 32'h00221820, 0, 0, 0); tick();
        chk_ex("stall_flush", 0, 0, 3'b000, 0, 0, 0, 0);
        stall = 1'b0;
        drive(1, 32'hFC000000, 0, 0, 0); tick();
        chk_ex("flush_illegal", 0, 0, 3'b000, 0, 0, 0, 0);
        flush = 1'b0;
        drive(1, 32'h00221820, 0, 0, 0); tick();
        chk_ex("wb_during_stall", 32'h10, 32'h99, 3'b010, 1, 5'd3, 1, 0);
        drive(0, 0, 1, 5'd0, 32'hDEAD); tick();
        drive(1, 32'h00003025, 0, 0, 0); tick();
        chk_ex("or_r0", 0, 0, 3'b001, 1, 5'd6, 1, 0);
        drive(1, 32'hFC000000, 0, 0, 0); tick();
        chk_ex("illegal_op", 0, 0, 3'b000, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0); tick();
        chk_ex("illegal_clear", 0, 0, 3'b000, 0, 0, 0, 0);
        drive(1, 32'h0000003F, 0, 0, 0); tick();
        chk_ex("illegal_funct", 0, 0, 3'b000, 0, 0, 0, 1);
        drive(0, 0, 1, 5'd1, 32'd9); tick();
        drive(1, 32'h10220000, 1, 5'd2, 32'd9); tick();
        chk_ex("beq", 32'd9, 32'd9, 3'b110, 1, 5'd0, 0, 0);
        drive(1, 32'h8C27FFFC, 0, 0, 0); tick();
        chk_ex("lw", 32'd9, 32'hFFFFFFFC, 3'b010, 1, 5'd7, 1, 0);
        drive(1, 32'hAC270008, 0, 0, 0); tick();
        chk_ex("sw", 32'd9, 32'd8, 3'b010, 1, 5'd0, 0, 0);
        drive(1, 32'h00224024, 0, 0, 0); tick();
        chk_ex("and", 32'd9, 32'd9, 3'b000, 1, 5'd8, 1, 0);
        drive(1, 32'h00224027, 0, 0, 0); tick();
        chk_ex("nor", 32'd9, 32'd9, 3'b100, 1, 5'd8, 1, 0);
        drive(1, 32'h0022402A, 5'd1, 5'd5, 32'h55); tick();
        chk_ex("slt", 32'd9, 32'd9, 3'b111, 1, 5'd8, 1, 0);
        drive(1, 32'h00A04820, 0, 0, 0); tick();
        chk_ex("read_r5", 32'h55, 32'd0, 3'b010, 1, 5'd9, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_ex("async_reset", 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 32'h00A04820, 0, 0, 0); tick();
        chk_ex("r5_after_reset", 0, 0, 3'b010, 1, 5'd9, 1, 0);
        drive(1, 32'h00221820, 0, 0, 0); tick();
        chk_ex("r1r2_after_reset", 0, 0, 3'b010, 1, 5'd3, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
